// File: rtl/regfile_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_ctrl_pkg
// Shared definitions for the bit-slice register-file sequencer.
//   - Default sizing (register count, multiplier width, scratch register).
//   - Command opcodes and the sequencer state encoding.
//   - onehot(): index to one-hot decode. It returns 32 bits and callers
//     size-cast the result to their own enable width.
// ---------------------------------------------------------------------------
package regfile_ctrl_pkg;

    localparam int NREG_DEF    = 5;
    localparam int WIDTH_DEF   = 8;
    localparam int TMP_REG_DEF = 4;
    localparam int IDX_W       = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADD_EX = 3'd1,
        CLR    = 3'd2,
        PP     = 3'd3,
        ACC    = 3'd4,
        SHIFT  = 3'd5,
        DONE   = 3'd6
    } state_t;

    function automatic logic [31:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/regfile_seq_ctrl_enable_pair_reg.sv
// ---------------------------------------------------------------------------
// enable_pair_reg
// Registered enable vector together with its registered complement. Both
// halves are real flops so that the pair is complementary in every cycle,
// including while reset is asserted (en_q = 0, en_n_q = all ones).
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   en_d    next enable value
//   en_q    registered enable
//   en_n_q  registered complement of en_q
// ---------------------------------------------------------------------------
module enable_pair_reg
    import regfile_ctrl_pkg::*;
#(
    parameter int W = NREG_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] en_d,
    output logic [W-1:0] en_q,
    output logic [W-1:0] en_n_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= '0;
            en_n_q <= '1;
        end else begin
            en_q   <= en_d;
            en_n_q <= ~en_d;
        end
    end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_seq_ctrl
// Sequencer for the bit-slice datapath. Accepts one ADD or MUL command at a
// time and drives the register-file read/write enables, the partial-product
// generator and the adder cycle by cycle. MUL is shift-add: one CLR cycle,
// then a PP / ACC / SHIFT triple per multiplier bit.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, op                  command strobe (IDLE only), 0=ADD 1=MUL
//   ra, rb, rd                 source A, source B, destination indices
//   mplier                     multiplier value, captured on accept
//   busy, done, err            status: busy through DONE, done/err pulses
//   rd_enA/_n, rd_enB/_n       one-hot read enables and complements
//   wr_en                      one-hot write enable (Z into register)
//   ppgen_en/_n, add_en/_n     datapath unit enables and complements
//   B_0                        current multiplier bit into pp_gen
//   Cin                        adder carry-in (always 0)
//   shift_en                   pulse to the external multiplicand shifter
// All outputs are registered: the output "next" values are decoded from the
// next state, so they appear in the same cycle the FSM enters that state.
// ---------------------------------------------------------------------------
module regfile_seq_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TMP_REG = TMP_REG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [IDX_W-1:0] ra,
    input  logic [IDX_W-1:0] rb,
    input  logic [IDX_W-1:0] rd,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NREG-1:0]  rd_enA,
    output logic [NREG-1:0]  rd_enA_n,
    output logic [NREG-1:0]  rd_enB,
    output logic [NREG-1:0]  rd_enB_n,
    output logic [NREG-1:0]  wr_en,
    output logic             ppgen_en,
    output logic             ppgen_en_n,
    output logic             add_en,
    output logic             add_en_n,
    output logic             B_0,
    output logic             Cin,
    output logic             shift_en
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] TMP_IDX  = IDX_W'(TMP_REG);

    // The write-enable complement is not a port; it is kept only so that the
    // write path uses the same pair register as the read ports.
    logic [NREG-1:0] wr_en_n_unused;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ra_q, ra_d;
    logic [IDX_W-1:0]   rb_q, rb_d;
    logic [IDX_W-1:0]   rd_q, rd_d;
    logic [WIDTH-1:0]   mreg_q, mreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               b0_q, b0_d;
    logic               shift_en_q, shift_en_d;

    logic [NREG-1:0]    rd_en_a_d;
    logic [NREG-1:0]    rd_en_b_d;
    logic [NREG-1:0]    wr_en_d;
    logic               ppgen_en_d;
    logic               add_en_d;

    logic               idx_ok;
    logic               mul_ok;
    logic               cmd_ok;

    // Command validation. rb is range-checked for both opcodes. MUL must not
    // use the scratch register as source or accumulator, and the multiplicand
    // must not alias the accumulator because it is read in every PP cycle.
    always_comb begin
        idx_ok = (int'(ra) < NREG) && (int'(rb) < NREG) && (int'(rd) < NREG);
        mul_ok = (ra != TMP_IDX) && (rd != TMP_IDX) && (ra != rd);
        cmd_ok = idx_ok && ((op == OP_ADD) || mul_ok);
    end

    // Next-state and datapath bookkeeping. The opcode is not stored
    // separately: the ADD_EX / CLR branch taken at accept encodes it.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rd_d    = rd_q;
        mreg_d  = mreg_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cmd_ok) begin
                        ra_d    = ra;
                        rb_d    = rb;
                        rd_d    = rd;
                        mreg_d  = mplier;
                        cnt_d   = '0;
                        state_d = (op == OP_MUL) ? CLR : ADD_EX;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ADD_EX: state_d = DONE;
            CLR:    state_d = PP;
            PP:     state_d = ACC;
            ACC:    state_d = SHIFT;
            SHIFT: begin
                mreg_d  = mreg_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_LAST) ? DONE : PP;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the state being entered, so the registered outputs
    // line up with the state register. B_0 in PP uses the post-shift value.
    always_comb begin
        rd_en_a_d  = '0;
        rd_en_b_d  = '0;
        wr_en_d    = '0;
        ppgen_en_d = 1'b0;
        add_en_d   = 1'b0;
        b0_d       = 1'b0;
        shift_en_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_d != IDLE);

        case (state_d)
            ADD_EX: begin
                rd_en_a_d = NREG'(onehot(ra_d));
                rd_en_b_d = NREG'(onehot(rb_d));
                add_en_d  = 1'b1;
                wr_en_d   = NREG'(onehot(rd_d));
            end
            CLR: begin
                // pp_gen with B_0=0 yields zero, clearing the accumulator.
                rd_en_a_d  = NREG'(onehot(ra_d));
                ppgen_en_d = 1'b1;
                wr_en_d    = NREG'(onehot(rd_d));
            end
            PP: begin
                rd_en_a_d  = NREG'(onehot(ra_d));
                ppgen_en_d = 1'b1;
                b0_d       = mreg_d[0];
                wr_en_d    = NREG'(onehot(TMP_IDX));
            end
            ACC: begin
                rd_en_a_d = NREG'(onehot(TMP_IDX));
                rd_en_b_d = NREG'(onehot(rd_d));
                add_en_d  = 1'b1;
                wr_en_d   = NREG'(onehot(rd_d));
            end
            SHIFT:   shift_en_d = 1'b1;
            DONE:    done_d     = 1'b1;
            default: ;
        endcase
    end

    // Reset is asserted asynchronously; release is expected to be
    // synchronised to clk upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ra_q       <= '0;
            rb_q       <= '0;
            rd_q       <= '0;
            mreg_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            b0_q       <= 1'b0;
            shift_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            rd_q       <= rd_d;
            mreg_q     <= mreg_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            b0_q       <= b0_d;
            shift_en_q <= shift_en_d;
        end
    end

    enable_pair_reg #(.W(NREG)) u_rd_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_d   (rd_en_a_d),
        .en_q   (rd_enA),
        .en_n_q (rd_enA_n)
    );

    enable_pair_reg #(.W(NREG)) u_rd_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_d   (rd_en_b_d),
        .en_q   (rd_enB),
        .en_n_q (rd_enB_n)
    );

    enable_pair_reg #(.W(NREG)) u_wr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_d   (wr_en_d),
        .en_q   (wr_en),
        .en_n_q (wr_en_n_unused)
    );

    enable_pair_reg #(.W(1)) u_ppgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_d   (ppgen_en_d),
        .en_q   (ppgen_en),
        .en_n_q (ppgen_en_n)
    );

    enable_pair_reg #(.W(1)) u_add (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_d   (add_en_d),
        .en_q   (add_en),
        .en_n_q (add_en_n)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign B_0      = b0_q;
    assign shift_en = shift_en_q;
    assign Cin      = 1'b0;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_seq_ctrl
// Self-checking bench for regfile_seq_ctrl. Each command is expanded by a
// behavioural model into the list of per-cycle output values it should
// produce (one entry per cycle after the accept edge, ending with an idle
// cycle); the bench then compares the DUT against that list on the falling
// edge. A free-running checker verifies complement, one-hot and mutual
// exclusion properties every cycle.
// ---------------------------------------------------------------------------
module tb_regfile_seq_ctrl;

    localparam int NREG  = 5;
    localparam int WIDTH = 8;
    localparam int TMP   = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             op;
    logic [2:0]       ra;
    logic [2:0]       rb;
    logic [2:0]       rd;
    logic [WIDTH-1:0] mplier;
    logic             busy;
    logic             done;
    logic             err;
    logic [NREG-1:0]  rd_enA;
    logic [NREG-1:0]  rd_enA_n;
    logic [NREG-1:0]  rd_enB;
    logic [NREG-1:0]  rd_enB_n;
    logic [NREG-1:0]  wr_en;
    logic             ppgen_en;
    logic             ppgen_en_n;
    logic             add_en;
    logic             add_en_n;
    logic             B_0;
    logic             Cin;
    logic             shift_en;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NREG-1:0] ena;
        logic [NREG-1:0] enb;
        logic [NREG-1:0] wr;
        logic            pp;
        logic            add;
        logic            b0;
        logic            sh;
        logic            busy;
        logic            done;
        logic            err;
    } exp_t;

    exp_t exp_q[$];

    regfile_seq_ctrl #(.NREG(NREG), .WIDTH(WIDTH), .TMP_REG(TMP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .ra         (ra),
        .rb         (rb),
        .rd         (rd),
        .mplier     (mplier),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_enA     (rd_enA),
        .rd_enA_n   (rd_enA_n),
        .rd_enB     (rd_enB),
        .rd_enB_n   (rd_enB_n),
        .wr_en      (wr_en),
        .ppgen_en   (ppgen_en),
        .ppgen_en_n (ppgen_en_n),
        .add_en     (add_en),
        .add_en_n   (add_en_n),
        .B_0        (B_0),
        .Cin        (Cin),
        .shift_en   (shift_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [NREG-1:0] ena, input logic [NREG-1:0] enb,
                                input logic [NREG-1:0] wr, input logic pp, input logic add,
                                input logic b0, input logic sh, input logic bsy,
                                input logic dn, input logic er);
        exp_t e;
        e.ena = ena; e.enb = enb; e.wr = wr; e.pp = pp; e.add = add;
        e.b0 = b0; e.sh = sh; e.busy = bsy; e.done = dn; e.err = er;
        return e;
    endfunction

    function automatic logic [NREG-1:0] bit_of(input int idx);
        return NREG'(1 << idx);
    endfunction

    // Reference model: expands one command into its expected per-cycle trace.
    task automatic push_cmd(input logic o, input int a, input int b, input int d,
                            input logic [WIDTH-1:0] mp);
        bit ok;
        ok = (a < NREG) && (b < NREG) && (d < NREG);
        if (o) ok = ok && (a != TMP) && (d != TMP) && (a != d);
        if (!ok) begin
            exp_q.push_back(mk('0, '0, '0, 0, 0, 0, 0, 0, 0, 1));
        end else if (!o) begin
            exp_q.push_back(mk(bit_of(a), bit_of(b), bit_of(d), 0, 1, 0, 0, 1, 0, 0));
            exp_q.push_back(mk('0, '0, '0, 0, 0, 0, 0, 1, 1, 0));
        end else begin
            exp_q.push_back(mk(bit_of(a), '0, bit_of(d), 1, 0, 0, 0, 1, 0, 0));
            for (int i = 0; i < WIDTH; i++) begin
                exp_q.push_back(mk(bit_of(a), '0, bit_of(TMP), 1, 0, mp[i], 0, 1, 0, 0));
                exp_q.push_back(mk(bit_of(TMP), bit_of(d), bit_of(d), 0, 1, 0, 0, 1, 0, 0));
                exp_q.push_back(mk('0, '0, '0, 0, 0, 0, 1, 1, 0, 0));
            end
            exp_q.push_back(mk('0, '0, '0, 0, 0, 0, 0, 1, 1, 0));
        end
        exp_q.push_back(mk('0, '0, '0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic check_entry(input string ctx, input exp_t e);
        check_eq({ctx, ".rd_enA"},   32'(rd_enA),   32'(e.ena));
        check_eq({ctx, ".rd_enB"},   32'(rd_enB),   32'(e.enb));
        check_eq({ctx, ".wr_en"},    32'(wr_en),    32'(e.wr));
        check_eq({ctx, ".ppgen_en"}, 32'(ppgen_en), 32'(e.pp));
        check_eq({ctx, ".add_en"},   32'(add_en),   32'(e.add));
        check_eq({ctx, ".B_0"},      32'(B_0),      32'(e.b0));
        check_eq({ctx, ".shift_en"}, 32'(shift_en), 32'(e.sh));
        check_eq({ctx, ".busy"},     32'(busy),     32'(e.busy));
        check_eq({ctx, ".done"},     32'(done),     32'(e.done));
        check_eq({ctx, ".err"},      32'(err),      32'(e.err));
        check_eq({ctx, ".Cin"},      32'(Cin),      32'd0);
    endtask

    // Present a command at the current falling edge and walk exp_q.
    // hold > 0 keeps start high until the falling edge of entry hold-1.
    // junk = 1 scrambles the command inputs and toggles start while busy.
    task automatic run_cmd(input string ctx, input logic o, input logic [2:0] a,
                           input logic [2:0] b, input logic [2:0] d,
                           input logic [WIDTH-1:0] mp, input int hold, input bit junk);
        op = o; ra = a; rb = b; rd = d; mplier = mp;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (hold == 0) start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_entry($sformatf("%s[%0d]", ctx, i), exp_q[i]);
            if (hold > 0) begin
                start = (i + 1 < hold);
            end else if (junk) begin
                ra = 3'($urandom); rb = 3'($urandom); rd = 3'($urandom);
                op = 1'($urandom); mplier = WIDTH'($urandom);
                start = exp_q[i].busy ? 1'($urandom) : 1'b0;
            end
        end
        $display("cmd %s op=%0d ra=%0d rb=%0d rd=%0d mp=%02h cycles=%0d", ctx, o, a, b, d, mp,
                 exp_q.size());
        exp_q.delete();
    endtask

    // Per-cycle structural properties, reset included.
    always @(negedge clk) begin
        check_eq("cmpA", 32'(rd_enA ^ rd_enA_n), 32'h1f);
        check_eq("cmpB", 32'(rd_enB ^ rd_enB_n), 32'h1f);
        check_eq("cmpPP", 32'(ppgen_en ^ ppgen_en_n), 32'd1);
        check_eq("cmpADD", 32'(add_en ^ add_en_n), 32'd1);
        check_eq("ohA", 32'($countones(rd_enA) <= 1), 32'd1);
        check_eq("ohB", 32'($countones(rd_enB) <= 1), 32'd1);
        check_eq("ohW", 32'($countones(wr_en) <= 1), 32'd1);
        check_eq("pp_add_excl", 32'(ppgen_en & add_en), 32'd0);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       o;
        logic [2:0] a, b, d;

        rst_n = 1'b0; start = 1'b0; op = 1'b0;
        ra = '0; rb = '0; rd = '0; mplier = '0;
        repeat (3) @(negedge clk);
        check_entry("reset", mk('0, '0, '0, 0, 0, 0, 0, 0, 0, 0));
        $display("reset state checked");
        rst_n = 1'b1;

        // Directed ADD.
        push_cmd(1'b0, 1, 2, 3, 8'h00);
        run_cmd("add123", 1'b0, 3'd1, 3'd2, 3'd3, 8'h00, 0, 1'b0);

        // Directed MUL, B_0 sequence 1,0,1,0,0,1,0,1.
        push_cmd(1'b1, 0, 1, 1, 8'hA5);
        run_cmd("mulA5", 1'b1, 3'd0, 3'd1, 3'd1, 8'hA5, 0, 1'b0);

        // Rejected commands.
        push_cmd(1'b1, 0, 0, 4, 8'h33);
        run_cmd("mul_rd_tmp", 1'b1, 3'd0, 3'd0, 3'd4, 8'h33, 0, 1'b0);
        push_cmd(1'b0, 5, 0, 1, 8'h00);
        run_cmd("add_ra5", 1'b0, 3'd5, 3'd0, 3'd1, 8'h00, 0, 1'b0);

        // start held high: DONE-cycle start ignored, second ADD starts in IDLE.
        push_cmd(1'b0, 2, 0, 4, 8'h00);
        push_cmd(1'b0, 2, 0, 4, 8'h00);
        run_cmd("add_held", 1'b0, 3'd2, 3'd0, 3'd4, 8'h00, 5, 1'b0);

        // Reset during ACC of a MUL.
        push_cmd(1'b1, 2, 0, 3, 8'hFF);
        op = 1'b1; ra = 3'd2; rb = 3'd0; rd = 3'd3; mplier = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_entry($sformatf("mulrst[%0d]", i), exp_q[i]);
        end
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst.wr_en", 32'(wr_en), 32'd0);
        check_eq("rst.rd_enA_n", 32'(rd_enA_n), 32'h1f);
        check_eq("rst.add_en_n", 32'(add_en_n), 32'd1);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.ppgen_en", 32'(ppgen_en), 32'd0);
        $display("reset mid-MUL checked");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_cmd(1'b0, 4, 3, 0, 8'h00);
        run_cmd("add_after_rst", 1'b0, 3'd4, 3'd3, 3'd0, 8'h00, 0, 1'b0);

        // Randomised commands with inputs scrambled while busy.
        for (int n = 0; n < 1000; n++) begin
            o = 1'($urandom);
            a = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            b = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            d = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            mplier = WIDTH'($urandom);
            push_cmd(o, int'(a), int'(b), int'(d), mplier);
            run_cmd($sformatf("rnd%0d", n), o, a, b, d, mplier, 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
